// File: rtl/pokey_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pokey_timer_scheduler
// Description : POKEY timer clock-enable scheduler, channel tick routing and
//               STIMER reload sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pokey_timer_scheduler #(
  parameter int DIV64 = 28,
  parameter int DIV15 = 114
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_179,
  input  logic       init,
  input  logic [7:0] audctl,
  input  logic       stimer_write,
  input  logic [3:0] underflow_delayed,
  output logic       enable_64,
  output logic       enable_15,
  output logic [3:0] chan_enable,
  output logic [3:0] chan_reload,
  output logic [3:0] delay_enable,
  output logic       delay_sync_reset
);

  localparam int W64 = (DIV64 > 1) ? $clog2(DIV64) : 1;
  localparam int W15 = (DIV15 > 1) ? $clog2(DIV15) : 1;
  localparam logic [W64-1:0] C_DIV64_LAST = W64'(DIV64 - 1);
  localparam logic [W15-1:0] C_DIV15_LAST = W15'(DIV15 - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } stimer_state_t;

  stimer_state_t  r_state;
  stimer_state_t  w_state_next;
  logic [W64-1:0] r_div64_cnt;
  logic [W64-1:0] w_div64_next;
  logic [W15-1:0] r_div15_cnt;
  logic [W15-1:0] w_div15_next;

  logic       w_active;
  logic       w_execute;
  logic       w_tick64;
  logic       w_tick15;
  logic       w_base;
  logic [3:0] w_sel_tick;
  logic [3:0] w_uf_reload;

  // Outputs are forced quiet both in init and while reset is asserted.
  assign w_active  = reset_n & ~init;
  assign w_execute = w_active & enable_179 & (r_state == ST_PENDING);

  assign w_tick64 = enable_179 & (r_div64_cnt == C_DIV64_LAST);
  assign w_tick15 = enable_179 & (r_div15_cnt == C_DIV15_LAST);

  // ---------------------------------------------------------------------------
  // State and divider registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_div64_cnt <= '0;
      r_div15_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_div64_cnt <= w_div64_next;
      r_div15_cnt <= w_div15_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: STIMER sequencer and base dividers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_div64_next = r_div64_cnt;
    w_div15_next = r_div15_cnt;

    case (r_state)
      ST_IDLE: begin
        if (stimer_write && !init) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // A repeated write while pending does nothing; the execute clears it.
        if (init || enable_179) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (init || w_execute) begin
      w_div64_next = '0;
      w_div15_next = '0;
    end else if (enable_179) begin
      w_div64_next = w_tick64 ? '0 : r_div64_cnt + 1'b1;
      w_div15_next = w_tick15 ? '0 : r_div15_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick routing and reload selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_base        = audctl[0] ? w_tick15 : w_tick64;
    w_sel_tick[0] = audctl[6] ? enable_179 : w_base;
    w_sel_tick[1] = audctl[4] ? underflow_delayed[0] : w_base;
    w_sel_tick[2] = audctl[5] ? enable_179 : w_base;
    w_sel_tick[3] = audctl[3] ? underflow_delayed[2] : w_base;

    // A linked low channel reloads with its high partner, not on its own wrap.
    w_uf_reload[0] = audctl[4] ? underflow_delayed[1] : underflow_delayed[0];
    w_uf_reload[1] = underflow_delayed[1];
    w_uf_reload[2] = audctl[3] ? underflow_delayed[3] : underflow_delayed[2];
    w_uf_reload[3] = underflow_delayed[3];
  end

  always_comb begin
    enable_64        = 1'b0;
    enable_15        = 1'b0;
    chan_enable      = 4'b0000;
    chan_reload      = 4'b0000;
    delay_enable     = 4'b0000;
    delay_sync_reset = 1'b0;

    if (!reset_n) begin
      delay_sync_reset = 1'b0;
    end else if (init) begin
      delay_sync_reset = 1'b1;
    end else if (w_execute) begin
      chan_reload      = 4'b1111;
      delay_sync_reset = 1'b1;
      delay_enable     = {4{enable_179}};
    end else begin
      enable_64    = w_tick64;
      enable_15    = w_tick15;
      chan_enable  = w_sel_tick;
      chan_reload  = w_uf_reload;
      delay_enable = {4{enable_179}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pokey_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pokey_timer_scheduler
// Description : Randomized and directed self-checking bench with a tick-count
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pokey_timer_scheduler;

  localparam int DIV64 = 28;
  localparam int DIV15 = 114;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable_179;
  logic       init;
  logic [7:0] audctl;
  logic       stimer_write;
  logic [3:0] underflow_delayed;
  logic       enable_64;
  logic       enable_15;
  logic [3:0] chan_enable;
  logic [3:0] chan_reload;
  logic [3:0] delay_enable;
  logic       delay_sync_reset;

  always #5 clk = ~clk;

  pokey_timer_scheduler #(.DIV64(DIV64), .DIV15(DIV15)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable_179        (enable_179),
    .init              (init),
    .audctl            (audctl),
    .stimer_write      (stimer_write),
    .underflow_delayed (underflow_delayed),
    .enable_64         (enable_64),
    .enable_15         (enable_15),
    .chan_enable       (chan_enable),
    .chan_reload       (chan_reload),
    .delay_enable      (delay_enable),
    .delay_sync_reset  (delay_sync_reset)
  );

  int checks = 0;
  int errors = 0;

  // Model: ticks seen since the dividers were last cleared, plus a pending flag.
  int m_ticks = 0;
  bit m_pend  = 1'b0;

  int cyc        = 0;
  int exec_seen  = 0;
  int first_e64  = -1;
  int first_e15  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare_and_update();
    bit         x_e64, x_e15, x_dsr, exec, base;
    logic [3:0] x_ce, x_cr, x_de;
    x_e64 = 0; x_e15 = 0; x_dsr = 0; x_ce = 0; x_cr = 0; x_de = 0; exec = 0;
    if (reset_n && init) begin
      x_dsr = 1;
    end else if (reset_n) begin
      exec = m_pend && enable_179;
      x_de = {4{enable_179}};
      if (exec) begin
        x_cr  = 4'hF;
        x_dsr = 1;
      end else begin
        x_e64 = enable_179 && ((m_ticks % DIV64) == DIV64 - 1);
        x_e15 = enable_179 && ((m_ticks % DIV15) == DIV15 - 1);
        base  = audctl[0] ? x_e15 : x_e64;
        x_ce[0] = audctl[6] ? enable_179 : base;
        x_ce[1] = audctl[4] ? underflow_delayed[0] : base;
        x_ce[2] = audctl[5] ? enable_179 : base;
        x_ce[3] = audctl[3] ? underflow_delayed[2] : base;
        x_cr[1] = underflow_delayed[1];
        x_cr[3] = underflow_delayed[3];
        x_cr[0] = audctl[4] ? underflow_delayed[1] : underflow_delayed[0];
        x_cr[2] = audctl[3] ? underflow_delayed[3] : underflow_delayed[2];
      end
    end
    check("enable_64",        32'(enable_64),        32'(x_e64));
    check("enable_15",        32'(enable_15),        32'(x_e15));
    check("chan_enable",      32'(chan_enable),      32'(x_ce));
    check("chan_reload",      32'(chan_reload),      32'(x_cr));
    check("delay_enable",     32'(delay_enable),     32'(x_de));
    check("delay_sync_reset", 32'(delay_sync_reset), 32'(x_dsr));

    if (reset_n && !init && chan_reload == 4'hF && delay_sync_reset) exec_seen++;
    if (enable_64 && first_e64 < 0) first_e64 = cyc;
    if (enable_15 && first_e15 < 0) first_e15 = cyc;

    if (!reset_n || init) begin
      m_ticks = 0;
      m_pend  = 0;
    end else if (exec) begin
      m_ticks = 0;
      m_pend  = 0;
    end else begin
      if (enable_179) m_ticks++;
      if (stimer_write) m_pend = 1;
    end
  endtask

  task automatic cycle(input bit e, input bit sw, input bit in, input logic [3:0] ud);
    enable_179        = e;
    stimer_write      = sw;
    init              = in;
    underflow_delayed = ud;
    @(negedge clk);
    compare_and_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive enable_179 every 'period' cycles, tick on phase 0.
  task automatic ticks(input int n, input int period);
    for (int i = 0; i < n; i++) cycle((i % period) == 0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    reset_n = 1'b0; enable_179 = 1'b1; init = 1'b0; audctl = 8'h00;
    stimer_write = 1'b0; underflow_delayed = 4'h0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'hF);
    check("reset_chan_enable", 32'(chan_enable), 32'h0);
    reset_n = 1'b1;

    // Divider timing from reset, ticks every cycle.
    cyc = 0; first_e64 = -1; first_e15 = -1;
    ticks(300, 1);
    check("first_enable_64", 32'(first_e64), 32'd27);
    check("first_enable_15", 32'(first_e15), 32'd113);

    // Clock select with ticks every second cycle.
    audctl = 8'h01; ticks(400, 2);
    audctl = 8'h41; ticks(400, 2);

    // Linking: ch1 clocked from ch0 underflow, ch0 reloads with ch1.
    audctl = 8'h10;
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 4'b0010);
    audctl = 8'h08;
    cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    cycle(1'b0, 1'b0, 1'b0, 4'b1000);
    audctl = 8'h00;

    // STIMER: write one cycle after a tick, ticks every 4th cycle.
    exec_seen = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    ticks(2, 4);
    cycle(1'b0, 1'b0, 1'b0, 4'h0);
    check("stimer_exec_count", 32'(exec_seen), 32'd1);
    first_e64 = -1; cyc = 0;
    ticks(4 * DIV64 + 4, 4);
    check("post_stimer_e64_cycle", 32'(first_e64), 32'(4 * (DIV64 - 1)));

    // Write coincident with a tick, then a double write: one execute each.
    exec_seen = 0;
    cycle(1'b1, 1'b1, 1'b0, 4'h0);
    check("coincident_no_exec", 32'(exec_seen), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'h0);
    ticks(8, 4);
    check("double_write_exec", 32'(exec_seen), 32'd1);

    // Async reset while pending: no execute afterwards.
    exec_seen = 0;
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_dsr", 32'(delay_sync_reset), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    reset_n = 1'b1;
    ticks(12, 4);
    check("reset_pending_no_exec", 32'(exec_seen), 32'd0);

    // Init held for 50 ticks with a write inside it.
    exec_seen = 0;
    for (int i = 0; i < 50; i++) cycle(1'b1, i == 20, 1'b1, 4'hF);
    cyc = 0; first_e64 = -1;
    ticks(40, 1);
    check("init_no_exec", 32'(exec_seen), 32'd0);
    check("post_init_e64", 32'(first_e64), 32'(DIV64 - 1));

    // Randomized traffic.
    for (int blk = 0; blk < 40; blk++) begin
      int  period;
      int  init_len;
      period   = $urandom_range(1, 6);
      audctl   = 8'($urandom);
      init_len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20) : 0;
      for (int i = 0; i < 150; i++) begin
        cycle(($urandom % period) == 0,
              ($urandom_range(0, 30) == 0),
              (i < init_len),
              ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pokey_timer_scheduler.md
Name: pokey_timer_scheduler

Overview:
- Clock-enable scheduler and reload sequencer for the four POKEY audio timers and their per-channel latch delay lines.
- Derives the 64 kHz and 15 kHz base ticks from the 1.79 MHz tick and routes the selected tick to each channel from AUDCTL, including 16-bit channel linking.
- Sequences STIMER: dividers cleared, delay lines flushed, all channels reloaded.
- Sits between the register file, the four channel down-counters and the delay lines.

Parameters:
- DIV64, 28, enable_179 ticks per enable_64 tick.
- DIV15, 114, enable_179 ticks per enable_15 tick.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable_179  in  1  one-cycle 1.79 MHz tick strobe.
- init  in  1  SKCTL[1:0]==00; holds scheduler in init.
- audctl  in  8  AUDCTL register value.
- stimer_write  in  1  one-cycle strobe on STIMER write.
- underflow_delayed  in  4  per-channel underflow pulses returned from the delay lines.
- enable_64  out  1  64 kHz tick strobe.
- enable_15  out  1  15 kHz tick strobe.
- chan_enable  out  4  per-channel decrement enable.
- chan_reload  out  4  per-channel reload request.
- delay_enable  out  4  enable to each channel's delay line.
- delay_sync_reset  out  1  synchronous flush of all delay lines.

Behaviour:
- Reset (reset_n=0, async): div64_cnt=0, div15_cnt=0, stimer_pending=0. All outputs 0.
- Dividers:
  - div64_cnt counts enable_179 cycles 0..DIV64-1 and wraps to 0.
  - enable_64 = enable_179 & (div64_cnt==DIV64-1); combinational from registered count, so it is high in the same cycle as the qualifying enable_179.
  - div15_cnt/enable_15 work the same way with DIV15.
  - The counts hold when enable_179=0.
- Init: while init=1, both counts are forced to 0 and held; enable_64, enable_15, chan_enable, chan_reload and delay_enable are 0; delay_sync_reset=1. Normal counting resumes the first cycle after init falls.
- Tick selection:
  - base = audctl[0] ? enable_15 : enable_64.
  - ch0 = audctl[6] ? enable_179 : base.
  - ch2 = audctl[5] ? enable_179 : base.
  - ch1 = audctl[4] ? underflow_delayed[0] : base.
  - ch3 = audctl[3] ? underflow_delayed[2] : base.
  - chan_enable is the selected tick, combinational.
- delay_enable[3:0] = {4{enable_179}} outside init.
- Reload, unlinked: chan_reload[i] = underflow_delayed[i].
- Reload, linked pair (audctl[4] for 0/1, audctl[3] for 2/3): the low channel reloads only on the high channel's delayed underflow, i.e. chan_reload[0] = underflow_delayed[1]. The high channel reloads on its own delayed underflow.
- STIMER state machine, IDLE / PENDING:
  - stimer_write=1 moves IDLE to PENDING.
  - In PENDING, the first subsequent cycle with enable_179=1 is the EXECUTE cycle:
    - chan_reload=4'b1111 and delay_sync_reset=1.
    - Both div counts are loaded to 0.
    - chan_enable=0 and enable_64=enable_15=0.
    - The state returns to IDLE.
  - A stimer_write in the same cycle as enable_179 sets PENDING; the execute happens at the next enable_179, never the same cycle.
  - A repeat stimer_write while PENDING is absorbed; only one execute occurs.
- Simultaneous events:
  - An execute cycle overrides all underflow-derived reloads; reload stays 1111 exactly once.
  - init=1 clears PENDING. A stimer_write during init is ignored.
  - An async reset mid-PENDING returns to IDLE with no execute.
- Latency: all strobes are zero-cycle combinational from registered state and inputs. STIMER execute occurs 1 to N cycles after the write, where N is the enable_179 spacing.

Test Plan:
- Divider: reset, init=0, enable_179 every cycle for 300 cycles. enable_64 pulses at cycles 27, 55, 83, ...; enable_15 pulses at 113, 227; each exactly 1 cycle wide.
- Clock select: audctl=8'h01, enable_179 every 2nd cycle. chan_enable[0] pulses coincide with enable_15. Set audctl=8'h41: chan_enable[0] equals enable_179 and chan_enable[2] equals enable_15.
- Linking: audctl=8'h10, pulse underflow_delayed[0]. chan_enable[1]=1 that cycle and chan_reload[0]=0. Pulse underflow_delayed[1]: chan_reload[0]=1 and chan_reload[1]=1.
- STIMER: enable_179 every 4th cycle, stimer_write 1 cycle after a tick. Exactly one cycle 3 cycles later shows chan_reload=1111, delay_sync_reset=1, chan_enable=0. The next enable_64 follows after 28 further ticks.
- STIMER edge cases: stimer_write coincident with enable_179 gives execute at the following tick. A double write gives a single execute. An async reset in PENDING gives no execute.
- Init: hold init=1 for 50 ticks. All enables and reloads are 0, delay_sync_reset=1, and a stimer_write is ignored. After release, the first enable_64 comes 28 ticks later.
